// File: rtl/commit_trace_checker_pkg.sv
// Shared types for the commit trace checker: trace entry layout, FSM states and the entry compare rule.
package commit_trace_checker_pkg;

  localparam int TRACE_ENTRY_W = 70;
  localparam int CNT_W         = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FAIL,
    HALT
  } state_t;

  // Register x0 is hardwired, so its writeback data carries no information.
  function automatic logic entry_match(trace_entry_t exp_e, trace_entry_t cmt_e);
    logic ok;
    ok = (exp_e.pc == cmt_e.pc) && (exp_e.wen == cmt_e.wen);
    if (exp_e.wen) begin
      ok = ok && (exp_e.waddr == cmt_e.waddr);
      if (exp_e.waddr != 5'd0) ok = ok && (exp_e.wdata == cmt_e.wdata);
    end
    return ok;
  endfunction

endpackage

// File: rtl/commit_trace_checker_if.sv
// Expected-trace load channel and processor commit channel, both val/rdy.
interface commit_trace_checker_if;

  logic        exp_val;
  logic        exp_rdy;
  logic [31:0] exp_pc;
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  logic        cmt_val;
  logic        cmt_rdy;
  logic [31:0] cmt_pc;
  logic        cmt_wen;
  logic [4:0]  cmt_waddr;
  logic [31:0] cmt_wdata;

  modport master (
    output exp_val, exp_pc, exp_wen, exp_waddr, exp_wdata,
    output cmt_val, cmt_pc, cmt_wen, cmt_waddr, cmt_wdata,
    input  exp_rdy, cmt_rdy
  );

  modport slave (
    input  exp_val, exp_pc, exp_wen, exp_waddr, exp_wdata,
    input  cmt_val, cmt_pc, cmt_wen, cmt_waddr, cmt_wdata,
    output exp_rdy, cmt_rdy
  );

endinterface

// File: rtl/commit_trace_checker_fifo.sv
// Expected-trace FIFO; one extra pointer bit separates full from empty, no read bypass.
module trace_fifo
  import commit_trace_checker_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [TRACE_ENTRY_W-1:0] push_dat,
  input  logic                     pop,
  output logic [TRACE_ENTRY_W-1:0] head_dat,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [TRACE_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/commit_trace_checker.sv
// Checks the in-order commit stream against a queued expected trace; sticky pass/fail and counters.
// Idle-commit watchdog is built only when COMMIT_TRACE_CHECKER_TIMEOUT_EN is defined.
module commit_trace_checker
  import commit_trace_checker_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_ON_ERR = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  commit_trace_checker_if.slave        bus,
  output logic                         done,
  output logic                         error,
  output logic [CNT_W-1:0]             num_checked,
  output logic [CNT_W-1:0]             num_errors,
  output logic [31:0]                  first_err_pc,
  output logic                         timeout
);

  state_t                   state_q;
  state_t                   state_d;
  trace_entry_t             exp_e;
  trace_entry_t             cmt_e;
  trace_entry_t             head_e;
  logic [TRACE_ENTRY_W-1:0] head_raw;
  logic                     full;
  logic                     empty;
  logic                     exp_rdy;
  logic                     cmt_rdy;
  logic                     push;
  logic                     pop;
  logic                     mism;
  logic                     to_hit;

  assign exp_e  = {bus.exp_pc, bus.exp_wen, bus.exp_waddr, bus.exp_wdata};
  assign cmt_e  = {bus.cmt_pc, bus.cmt_wen, bus.cmt_waddr, bus.cmt_wdata};
  assign head_e = trace_entry_t'(head_raw);

  // Ready depends on registered state only so upstream val never loops back into rdy.
  assign exp_rdy     = !full && (state_q != HALT);
  assign cmt_rdy     = !empty && (state_q != HALT);
  assign bus.exp_rdy = exp_rdy;
  assign bus.cmt_rdy = cmt_rdy;
  assign push        = bus.exp_val && exp_rdy;
  assign pop         = bus.cmt_val && cmt_rdy;
  assign mism        = pop && !entry_match(head_e, cmt_e);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (exp_e),
    .pop      (pop),
    .head_dat (head_raw),
    .full     (full),
    .empty    (empty)
  );

`ifdef COMMIT_TRACE_CHECKER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout_q;

  assign to_hit  = !empty && !pop && (idle_cnt == 32'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt <= (empty || pop) ? 32'd0 : idle_cnt + 32'd1;
      if (to_hit) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign to_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = ACTIVE;
      ACTIVE:  if (mism) state_d = (HALT_ON_ERR != 0) ? HALT : FAIL;
      FAIL:    state_d = FAIL;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_checked  <= '0;
      num_errors   <= '0;
      error        <= 1'b0;
      first_err_pc <= '0;
    end else begin
      if (pop && (num_checked != '1)) num_checked <= num_checked + CNT_W'(1);
      if (mism) begin
        if (num_errors != '1) num_errors <= num_errors + CNT_W'(1);
        if (!error) first_err_pc <= bus.cmt_pc;
      end
      if (mism || to_hit) error <= 1'b1;
    end
  end

  assign done = empty && (num_checked != '0);

endmodule
